// File: rtl/replica_pkg.sv
// Shared widths, command encoding and state types for the replica-exchange judge.
package replica_pkg;

    localparam int dist_bit  = 16;
    localparam int beta_bit  = 16;
    localparam int beta_frac = 8;
    localparam int delta_bit = dist_bit + 1;
    localparam int prod_bit  = dist_bit + beta_bit + 1;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PREV = 2'd1,
        FOLW = 2'd2,
        SELF = 2'd3
    } exchange_command_t;

    typedef enum logic [1:0] {
        ROLE_ALONE = 2'd0,
        ROLE_LOWER = 2'd1,
        ROLE_UPPER = 2'd2
    } exchange_role_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIFF  = 3'd1,
        MUL   = 3'd2,
        CMP   = 3'd3,
        ISSUE = 3'd4
    } judge_state_t;

    // Sign-extend a distance difference to the full product width.
    function automatic logic [prod_bit-1:0] sext_delta(input logic signed [delta_bit-1:0] d);
        return {{(prod_bit - delta_bit){d[delta_bit-1]}}, d};
    endfunction

endpackage

// File: rtl/exchange_metropolis.sv
// Two-stage Metropolis test: signed multiply, then threshold compare. The
// accept output is a registered pulse that is only high for a LOWER replica.
module exchange_metropolis
    import replica_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_enable,
    input  logic signed [delta_bit-1:0] delta,
    input  logic        [beta_bit-1:0]  delta_beta,
    input  logic        [beta_bit-1:0]  neg_log_rand,
    output logic                        accept
);

    logic signed [prod_bit-1:0] prod_d;
    logic signed [prod_bit-1:0] prod_q;
    logic        [beta_bit-1:0] nlr_d;
    logic        [beta_bit-1:0] nlr_q;
    logic                       valid_d;
    logic                       valid_q;
    logic                       enable_d;
    logic                       enable_q;
    logic                       accept_d;
    logic                       accept_q;
    logic signed [prod_bit-1:0] scaled_s;
    logic                       nonpos_s;

    // Multiply stage: both operands widened so the product is exact.
    always_comb begin
        prod_d   = $signed(sext_delta(delta)) * $signed({{(prod_bit - beta_bit){1'b0}}, delta_beta});
        nlr_d    = neg_log_rand;
        valid_d  = in_valid;
        enable_d = in_enable;
    end

    // Compare stage: non-positive products always accept.
    always_comb begin
        scaled_s = prod_q >>> beta_frac;
        nonpos_s = prod_q[prod_bit-1] | ~(|prod_q);
        if (!valid_q || !enable_q) begin
            accept_d = 1'b0;
        end else if (nonpos_s) begin
            accept_d = 1'b1;
        end else begin
            accept_d = ($unsigned(scaled_s) <= {{(prod_bit - beta_bit){1'b0}}, nlr_q});
        end
    end

    // Pipeline control flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            enable_q <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            enable_q <= enable_d;
            accept_q <= accept_d;
        end
    end

    // Pipeline data flops.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        nlr_q  <= nlr_d;
    end

    assign accept = accept_q;

endmodule

// File: rtl/exchange_judge.sv
// Replica-exchange judge: captures a round's operands, decides swap acceptance
// with its neighbour and emits a one-cycle exchange command four cycles after start.
module exchange_judge
    import replica_pkg::*;
#(
    parameter int REPLICA_ID  = 0,
    parameter int REPLICA_NUM = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    phase_odd,
    input  logic [dist_bit-1:0]     self_dist,
    input  logic [dist_bit-1:0]     folw_dist,
    input  logic [beta_bit-1:0]     delta_beta,
    input  logic [beta_bit-1:0]     neg_log_rand,
    output logic                    flag_out,
    input  logic                    flag_in,
    output exchange_command_t       command,
    output logic                    busy
);

    localparam logic ID_ODD   = 1'(REPLICA_ID % 2);
    localparam logic HAS_FOLW = ((REPLICA_ID + 1) < REPLICA_NUM);
    localparam logic HAS_PREV = (REPLICA_ID >= 1);

    judge_state_t               state_d;
    judge_state_t               state_q;
    logic                       busy_d;
    logic                       busy_q;
    exchange_role_t             role_d;
    exchange_role_t             role_q;
    logic [dist_bit-1:0]        self_d;
    logic [dist_bit-1:0]        self_q;
    logic [dist_bit-1:0]        folw_d;
    logic [dist_bit-1:0]        folw_q;
    logic [beta_bit-1:0]        dbeta_d;
    logic [beta_bit-1:0]        dbeta_q;
    logic [beta_bit-1:0]        nlr_d;
    logic [beta_bit-1:0]        nlr_q;
    logic signed [delta_bit-1:0] delta_d;
    logic signed [delta_bit-1:0] delta_q;
    logic                       capture_s;
    logic                       accept_s;
    exchange_command_t          command_s;

    // Round sequencing; a start outside IDLE is simply not seen.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DIFF;
                    capture_s = 1'b1;
                end else begin
                    state_d   = IDLE;
                    capture_s = 1'b0;
                end
            end
            DIFF:    state_d = MUL;
            MUL:     state_d = CMP;
            CMP:     state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Role decode and operand capture at an accepted start.
    always_comb begin
        if (capture_s) begin
            if ((ID_ODD == phase_odd) && HAS_FOLW) begin
                role_d = ROLE_LOWER;
            end else if ((ID_ODD != phase_odd) && HAS_PREV) begin
                role_d = ROLE_UPPER;
            end else begin
                role_d = ROLE_ALONE;
            end
            self_d  = self_dist;
            folw_d  = folw_dist;
            dbeta_d = delta_beta;
            nlr_d   = neg_log_rand;
        end else begin
            role_d  = role_q;
            self_d  = self_q;
            folw_d  = folw_q;
            dbeta_d = dbeta_q;
            nlr_d   = nlr_q;
        end
        delta_d = $signed({1'b0, folw_q}) - $signed({1'b0, self_q});
    end

    // FSM and busy flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Operand flops; only meaningful inside a round, so no reset.
    always_ff @(posedge clk) begin
        role_q  <= role_d;
        self_q  <= self_d;
        folw_q  <= folw_d;
        dbeta_q <= dbeta_d;
        nlr_q   <= nlr_d;
        delta_q <= delta_d;
    end

    exchange_metropolis u_metropolis (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (state_q == MUL),
        .in_enable    (role_q == ROLE_LOWER),
        .delta        (delta_q),
        .delta_beta   (dbeta_q),
        .neg_log_rand (nlr_q),
        .accept       (accept_s)
    );

    // The upper replica must follow its neighbour's flag in the same cycle,
    // so flag_in is the one input that reaches command without a flop.
    always_comb begin
        command_s = NOP;
        if (state_q == ISSUE) begin
            case (role_q)
                ROLE_LOWER: command_s = accept_s ? FOLW : SELF;
                ROLE_UPPER: command_s = flag_in ? PREV : SELF;
                default:    command_s = SELF;
            endcase
        end else begin
            command_s = NOP;
        end
    end

    assign command  = command_s;
    assign flag_out = accept_s;
    assign busy     = busy_q;

endmodule

// File: tb/tb_exchange_judge.sv
// Bench for exchange_judge: directed vector table, restart/reset sequences,
// and randomized rounds scored against a plain-arithmetic acceptance model.
module tb_exchange_judge;
    import replica_pkg::*;

    typedef struct {
        bit                phase;
        int                sdist;
        int                fdist;
        int                dbeta;
        int                nlr;
        bit                fin;
        exchange_command_t e0;
        exchange_command_t e2;
        exchange_command_t e3;
        exchange_command_t e31;
        bit                f0;
        bit                f2;
        bit                f3;
        bit                f31;
    } vec_t;

    logic clk = 1'b0;
    logic reset_s, start_s, phase_s, flag_s;
    logic [dist_bit-1:0] self_s, folw_s;
    logic [beta_bit-1:0] dbeta_s, nlr_s;
    logic [dist_bit-1:0] chain_dist [5];
    exchange_command_t cmd0, cmd2, cmd3, cmd31;
    logic fo0, fo2, fo3, fo31, busy0, busy2, busy3, busy31;
    exchange_command_t ccmd [4];
    logic [3:0] cflag, cfin, cbusy;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    exchange_judge #(.REPLICA_ID(0), .REPLICA_NUM(32)) u_id0 (
        .clk(clk), .reset(reset_s), .start(start_s), .phase_odd(phase_s),
        .self_dist(self_s), .folw_dist(folw_s), .delta_beta(dbeta_s), .neg_log_rand(nlr_s),
        .flag_out(fo0), .flag_in(1'b0), .command(cmd0), .busy(busy0));
    exchange_judge #(.REPLICA_ID(2), .REPLICA_NUM(32)) u_id2 (
        .clk(clk), .reset(reset_s), .start(start_s), .phase_odd(phase_s),
        .self_dist(self_s), .folw_dist(folw_s), .delta_beta(dbeta_s), .neg_log_rand(nlr_s),
        .flag_out(fo2), .flag_in(flag_s), .command(cmd2), .busy(busy2));
    exchange_judge #(.REPLICA_ID(3), .REPLICA_NUM(32)) u_id3 (
        .clk(clk), .reset(reset_s), .start(start_s), .phase_odd(phase_s),
        .self_dist(self_s), .folw_dist(folw_s), .delta_beta(dbeta_s), .neg_log_rand(nlr_s),
        .flag_out(fo3), .flag_in(flag_s), .command(cmd3), .busy(busy3));
    exchange_judge #(.REPLICA_ID(31), .REPLICA_NUM(32)) u_id31 (
        .clk(clk), .reset(reset_s), .start(start_s), .phase_odd(phase_s),
        .self_dist(self_s), .folw_dist(folw_s), .delta_beta(dbeta_s), .neg_log_rand(nlr_s),
        .flag_out(fo31), .flag_in(flag_s), .command(cmd31), .busy(busy31));

    assign cfin = {cflag[2:0], 1'b0};

    for (genvar i = 0; i < 4; i++) begin : g_chain
        exchange_judge #(.REPLICA_ID(i), .REPLICA_NUM(4)) u_c (
            .clk(clk), .reset(reset_s), .start(start_s), .phase_odd(phase_s),
            .self_dist(chain_dist[i]), .folw_dist(chain_dist[i+1]),
            .delta_beta(dbeta_s), .neg_log_rand(nlr_s),
            .flag_out(cflag[i]), .flag_in(cfin[i]), .command(ccmd[i]), .busy(cbusy[i]));
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit model_lower(int id, int num, bit ph);
        return ((id % 2) == int'(ph)) && (id + 1 < num);
    endfunction

    function automatic bit model_upper(int id, int num, bit ph);
        return ((id % 2) != int'(ph)) && (id >= 1);
    endfunction

    // Metropolis rule in plain integer arithmetic.
    function automatic bit model_accept(int s, int f, int db, int nlr);
        longint prod;
        prod = (longint'(f) - longint'(s)) * longint'(db);
        if (prod <= 0) return 1'b1;
        return (prod / (longint'(1) << beta_frac)) <= longint'(nlr);
    endfunction

    function automatic bit model_flag(int id, int num, bit ph, int s, int f, int db, int nlr);
        return model_lower(id, num, ph) && model_accept(s, f, db, nlr);
    endfunction

    function automatic exchange_command_t model_cmd(int id, int num, bit ph, int s, int f,
                                                    int db, int nlr, bit fin);
        if (model_lower(id, num, ph)) return model_accept(s, f, db, nlr) ? FOLW : SELF;
        if (model_upper(id, num, ph)) return fin ? PREV : SELF;
        return SELF;
    endfunction

    // One full round; inputs are scrambled after start to prove they were captured.
    task automatic run_round(input vec_t v, input int idx);
        int cd [5];
        bit fin;
        for (int i = 0; i < 5; i++) cd[i] = int'($urandom_range(0, 3000));
        @(negedge clk);
        phase_s = v.phase;
        self_s  = dist_bit'(v.sdist);
        folw_s  = dist_bit'(v.fdist);
        dbeta_s = beta_bit'(v.dbeta);
        nlr_s   = beta_bit'(v.nlr);
        flag_s  = v.fin;
        for (int i = 0; i < 5; i++) chain_dist[i] = dist_bit'(cd[i]);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check($sformatf("busy_diff[%0d]", idx), int'(busy2), 1);
        check($sformatf("nop_diff[%0d]", idx), int'(cmd2), int'(NOP));
        self_s  = dist_bit'($urandom);
        folw_s  = dist_bit'($urandom);
        dbeta_s = beta_bit'($urandom);
        nlr_s   = beta_bit'($urandom);
        for (int i = 0; i < 5; i++) chain_dist[i] = dist_bit'($urandom);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("nop_cmp[%0d]", idx), int'(cmd2), int'(NOP));
        check($sformatf("flag_cmp[%0d]", idx), int'(fo2), 0);
        @(negedge clk);
        check($sformatf("cmd_id0[%0d]", idx), int'(cmd0), int'(v.e0));
        check($sformatf("cmd_id2[%0d]", idx), int'(cmd2), int'(v.e2));
        check($sformatf("cmd_id3[%0d]", idx), int'(cmd3), int'(v.e3));
        check($sformatf("cmd_id31[%0d]", idx), int'(cmd31), int'(v.e31));
        check($sformatf("flag_id0[%0d]", idx), int'(fo0), int'(v.f0));
        check($sformatf("flag_id2[%0d]", idx), int'(fo2), int'(v.f2));
        check($sformatf("flag_id3[%0d]", idx), int'(fo3), int'(v.f3));
        check($sformatf("flag_id31[%0d]", idx), int'(fo31), int'(v.f31));
        check($sformatf("busy_issue[%0d]", idx), int'(busy2), 1);
        for (int i = 0; i < 4; i++) begin
            fin = (i == 0) ? 1'b0 : model_flag(i - 1, 4, v.phase, cd[i-1], cd[i], v.dbeta, v.nlr);
            check($sformatf("chain_cmd%0d[%0d]", i, idx), int'(ccmd[i]),
                  int'(model_cmd(i, 4, v.phase, cd[i], cd[i+1], v.dbeta, v.nlr, fin)));
            check($sformatf("chain_flag%0d[%0d]", i, idx), int'(cflag[i]),
                  int'(model_flag(i, 4, v.phase, cd[i], cd[i+1], v.dbeta, v.nlr)));
        end
        @(negedge clk);
        check($sformatf("nop_after[%0d]", idx), int'(cmd2), int'(NOP));
        check($sformatf("nop_after_id3[%0d]", idx), int'(cmd3), int'(NOP));
        check($sformatf("flag_after[%0d]", idx), int'(fo2), 0);
        check($sformatf("busy_after[%0d]", idx), int'(busy2), 0);
    endtask

    // Start at cycle 0, ignored start at cycle 2, reset at cycle rst_at.
    task automatic seq_restart(input int rst_at);
        int pulses = 0;
        int pulse_cyc = -1;
        int flags = 0;
        exchange_command_t seen = NOP;
        phase_s = 1'b0;
        flag_s  = 1'b0;
        dbeta_s = beta_bit'(256);
        nlr_s   = beta_bit'(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (cmd2 != NOP) begin
                    pulses++;
                    pulse_cyc = c;
                    seen = cmd2;
                end
                if (fo2) flags++;
                if (c == 1) check($sformatf("restart_busy_c1_r%0d", rst_at), int'(busy2), 1);
                if (c == rst_at + 1) check($sformatf("restart_busy_post_r%0d", rst_at), int'(busy2), 0);
            end
            start_s = (c == 0) || (c == 2);
            reset_s = (c == rst_at);
            if (c == 0) begin
                self_s = dist_bit'(1000);
                folw_s = dist_bit'(900);
            end else if (c == 2) begin
                self_s = dist_bit'(900);
                folw_s = dist_bit'(1000);
            end
        end
        start_s = 1'b0;
        reset_s = 1'b0;
        if (rst_at > 4) begin
            check("restart_pulses", pulses, 1);
            check("restart_pulse_cycle", pulse_cyc, 4);
            check("restart_pulse_cmd", int'(seen), int'(FOLW));
            check("restart_flag_cycles", flags, 1);
        end else begin
            check("abort_pulses", pulses, 0);
            check("abort_flag_cycles", flags, 0);
        end
    endtask

    initial begin
        vec_t vecs [11];
        vec_t v;
        // neg_log_rand values are given in the units of the scaled product.
        vecs[0]  = '{1'b0, 1000, 900, 256, 0, 1'b1, FOLW, FOLW, PREV, PREV, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 900, 1000, 256, 50, 1'b0, SELF, SELF, SELF, SELF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 900, 1000, 256, 150, 1'b1, FOLW, FOLW, PREV, PREV, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1000, 900, 256, 0, 1'b1, SELF, PREV, FOLW, SELF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 500, 500, 65535, 0, 1'b0, FOLW, FOLW, SELF, SELF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 0, 65535, 0, 0, 1'b1, FOLW, FOLW, PREV, PREV, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 0, 65535, 65535, 65535, 1'b0, SELF, SELF, SELF, SELF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 0, 256, 256, 256, 1'b0, FOLW, FOLW, SELF, SELF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 0, 256, 256, 255, 1'b1, SELF, SELF, PREV, PREV, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 900, 1000, 256, 50, 1'b0, SELF, SELF, SELF, SELF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 900, 1000, 256, 150, 1'b0, SELF, SELF, FOLW, SELF, 1'b0, 1'b0, 1'b1, 1'b0};

        reset_s = 1'b1;
        start_s = 1'b0;
        phase_s = 1'b0;
        flag_s  = 1'b0;
        self_s  = '0;
        folw_s  = '0;
        dbeta_s = '0;
        nlr_s   = '0;
        for (int i = 0; i < 5; i++) chain_dist[i] = '0;
        repeat (3) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("reset_cmd_id2", int'(cmd2), int'(NOP));
        check("reset_cmd_id3", int'(cmd3), int'(NOP));
        check("reset_flags", int'({fo0, fo2, fo3, fo31}), 0);
        check("reset_busy", int'({busy0, busy2, busy3, busy31}), 0);
        check("reset_chain_busy", int'(cbusy), 0);
        check("reset_chain_flags", int'(cflag), 0);
        reset_s = 1'b0;

        for (int i = 0; i < 11; i++) run_round(vecs[i], i);

        seq_restart(6);
        seq_restart(2);

        for (int r = 0; r < 40; r++) begin
            v.phase = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                v.sdist = int'($urandom_range(0, 65535));
                v.fdist = int'($urandom_range(0, 65535));
            end else begin
                v.sdist = int'($urandom_range(0, 3000));
                v.fdist = int'($urandom_range(0, 3000));
            end
            v.dbeta = int'($urandom_range(0, 1024));
            v.nlr   = int'($urandom_range(0, 12000));
            v.fin   = 1'($urandom_range(0, 1));
            v.e0    = model_cmd(0, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr, 1'b0);
            v.e2    = model_cmd(2, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr, v.fin);
            v.e3    = model_cmd(3, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr, v.fin);
            v.e31   = model_cmd(31, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr, v.fin);
            v.f0    = model_flag(0, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr);
            v.f2    = model_flag(2, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr);
            v.f3    = model_flag(3, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr);
            v.f31   = model_flag(31, 32, v.phase, v.sdist, v.fdist, v.dbeta, v.nlr);
            run_round(v, 100 + r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
